// File: rtl/user_locked_regfile.sv
// Register file with per-register owner IDs and sticky admin locks.
// Optional saturating violation counter: define USER_LOCK_VIOL_CNT_EN.
module user_locked_regfile #(
  parameter int DATA_W = 8,
  parameter int NUM_REGS = 4,
  parameter int ID_W = 2,
  parameter logic [ID_W-1:0] DEFAULT_OWNER = 2'h2,
  parameter logic [ID_W-1:0] ADMIN_ID = 2'h3,
  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ID_W-1:0]   usr_id,
  input  logic              wr_en,
  input  logic [1:0]        op,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              wr_ack,
  output logic              wr_err
`ifdef USER_LOCK_VIOL_CNT_EN
  ,
  output logic [7:0]        viol_cnt
`endif
);

  localparam logic [AW:0] NREGS = (AW+1)'(NUM_REGS);
  localparam logic [1:0] OP_DATA = 2'b00;
  localparam logic [1:0] OP_OWN  = 2'b01;
  localparam logic [1:0] OP_LOCK = 2'b10;

  logic [DATA_W-1:0] data_q  [NUM_REGS];
  logic [ID_W-1:0]   owner_q [NUM_REGS];
  logic [NUM_REGS-1:0] lock_q;

  logic          in_range;
  logic [AW-1:0] idx;
  logic          wr_ok;

  assign in_range = {1'b0, addr} < NREGS;
  assign idx = in_range ? addr : '0;

  always_comb begin
    wr_ok = 1'b0;
    if (in_range) begin
      unique case (op)
        OP_DATA: wr_ok = (usr_id == owner_q[idx]) && !lock_q[idx];
        OP_OWN:  wr_ok = (usr_id == ADMIN_ID) && !lock_q[idx];
        OP_LOCK: wr_ok = (usr_id == ADMIN_ID);
        default: wr_ok = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        data_q[i]  <= '0;
        owner_q[i] <= DEFAULT_OWNER;
      end
      lock_q <= '0;
    end else if (wr_en && wr_ok) begin
      unique case (op)
        OP_DATA: data_q[idx]  <= data_in;
        OP_OWN:  owner_q[idx] <= data_in[ID_W-1:0];
        OP_LOCK: lock_q[idx]  <= 1'b1;
        default: ;
      endcase
    end
  end

  // Read samples pre-write contents, so a same-edge write is not visible
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      wr_ack   <= 1'b0;
      wr_err   <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      wr_ack   <= wr_en && wr_ok;
      wr_err   <= wr_en && !wr_ok;
      if (rd_en) rd_data <= in_range ? data_q[idx] : '0;
    end
  end

`ifdef USER_LOCK_VIOL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) viol_cnt <= '0;
    else if (wr_en && !wr_ok && viol_cnt != 8'hFF)
      viol_cnt <= viol_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_user_locked_regfile.sv
// Self-checking bench for user_locked_regfile with a behavioural model.
// Directed scenarios followed by randomized traffic.
module tb_user_locked_regfile;

  localparam int NR = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] usr_id = '0;
  logic       wr_en = 1'b0;
  logic [1:0] op = '0;
  logic [1:0] addr = '0;
  logic [7:0] data_in = '0;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       wr_ack;
  logic       wr_err;
`ifdef USER_LOCK_VIOL_CNT_EN
  logic [7:0] viol_cnt;
`endif

  user_locked_regfile dut (
    .clk(clk), .rst_n(rst_n), .usr_id(usr_id), .wr_en(wr_en),
    .op(op), .addr(addr), .data_in(data_in), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_ack(wr_ack), .wr_err(wr_err)
`ifdef USER_LOCK_VIOL_CNT_EN
    , .viol_cnt(viol_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] m_data [NR];
  logic [1:0] m_owner [NR];
  bit         m_lock [NR];
  int         m_viol;

  logic       exp_ack, exp_err, exp_rv;
  logic [7:0] exp_rd;

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_data[i] = 8'h00;
      m_owner[i] = 2'd2;
      m_lock[i] = 1'b0;
    end
    m_viol = 0;
    exp_ack = 0; exp_err = 0; exp_rv = 0; exp_rd = 8'h00;
  endtask

  function automatic bit allowed(logic [1:0] id, logic [1:0] o,
                                 logic [1:0] a);
    if (int'(a) >= NR) return 1'b0;
    if (o == 2'b00) return id == m_owner[a] && !m_lock[a];
    if (o == 2'b01) return id == 2'd3 && !m_lock[a];
    if (o == 2'b10) return id == 2'd3;
    return 1'b0;
  endfunction

  task automatic step(input logic [1:0] id, input logic we,
                      input logic [1:0] o, input logic [1:0] a,
                      input logic [7:0] d, input logic re);
    bit acc;
    usr_id = id; wr_en = we; op = o; addr = a;
    data_in = d; rd_en = re;
    acc = allowed(id, o, a);
    exp_ack = we && acc;
    exp_err = we && !acc;
    exp_rv = re;
    if (re) exp_rd = (int'(a) < NR) ? m_data[a] : 8'h00;
    if (we && acc) begin
      if (o == 2'b00) m_data[a] = d;
      else if (o == 2'b01) m_owner[a] = d[1:0];
      else if (o == 2'b10) m_lock[a] = 1'b1;
    end
    if (we && !acc && m_viol < 255) m_viol++;
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic chk_wr(input string name, input logic ack,
                        input logic err);
    n_checks++;
    if (wr_ack !== ack || wr_err !== err) begin
      n_fail++;
      $display("FAIL %s: ack/err=%b%b required %b%b",
               name, wr_ack, wr_err, ack, err);
    end
  endtask

  task automatic test_reset();
    model_reset();
    #1;
    n_checks++;
    if ({rd_data, rd_valid, wr_ack, wr_err} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_outs: got %h/%b%b%b required 0",
               rd_data, rd_valid, wr_ack, wr_err);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < NR; i++) begin
      step(2'd0, 1'b0, 2'b00, 2'(i), 8'h00, 1'b1);
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_data[%0d]: got %b/%h required 1/00",
                 i, rd_valid, rd_data);
      end
    end
  endtask

  task automatic test_write_ok();
    step(2'd2, 1'b1, 2'b00, 2'd1, 8'hA5, 1'b0);
    n_checks++;
    if (wr_ack !== 1'b1 || wr_err !== 1'b0) begin
      n_fail++;
      $display("FAIL owner_write: ack/err=%b%b required 10",
               wr_ack, wr_err);
    end
    step(2'd0, 1'b0, 2'b00, 2'd1, 8'h00, 1'b1);
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL owner_read: got %b/%h required 1/a5",
               rd_valid, rd_data);
    end
  endtask

  task automatic test_write_denied();
    step(2'd1, 1'b1, 2'b00, 2'd1, 8'h3C, 1'b0);
    n_checks++;
    if (wr_ack !== 1'b0 || wr_err !== 1'b1) begin
      n_fail++;
      $display("FAIL intruder_write: ack/err=%b%b required 01",
               wr_ack, wr_err);
    end
`ifdef USER_LOCK_VIOL_CNT_EN
    n_checks++;
    if (viol_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL viol_cnt: got %0d required 1", viol_cnt);
    end
`endif
    step(2'd0, 1'b0, 2'b00, 2'd1, 8'h00, 1'b1);
    n_checks++;
    if (rd_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL denied_keep: got %h required a5", rd_data);
    end
  endtask

  task automatic test_set_owner();
    step(2'd3, 1'b1, 2'b01, 2'd0, 8'h01, 1'b0);
    chk_wr("set_owner", 1'b1, 1'b0);
    step(2'd1, 1'b1, 2'b00, 2'd0, 8'h77, 1'b0);
    chk_wr("new_owner_write", 1'b1, 1'b0);
    step(2'd2, 1'b1, 2'b00, 2'd0, 8'h99, 1'b0);
    chk_wr("old_owner_write", 1'b0, 1'b1);
    step(2'd1, 1'b1, 2'b01, 2'd0, 8'h01, 1'b0);
    chk_wr("non_admin_set_owner", 1'b0, 1'b1);
    step(2'd0, 1'b0, 2'b00, 2'd0, 8'h00, 1'b1);
    n_checks++;
    if (rd_data !== 8'h77) begin
      n_fail++;
      $display("FAIL owner0_data: got %h required 77", rd_data);
    end
  endtask

  task automatic test_lock();
    step(2'd3, 1'b1, 2'b10, 2'd2, 8'h00, 1'b0);
    chk_wr("lock", 1'b1, 1'b0);
    step(2'd2, 1'b1, 2'b00, 2'd2, 8'h12, 1'b0);
    chk_wr("locked_owner_write", 1'b0, 1'b1);
    step(2'd3, 1'b1, 2'b00, 2'd2, 8'h34, 1'b0);
    chk_wr("locked_admin_write", 1'b0, 1'b1);
    step(2'd3, 1'b1, 2'b01, 2'd2, 8'h03, 1'b0);
    chk_wr("locked_set_owner", 1'b0, 1'b1);
    step(2'd3, 1'b1, 2'b10, 2'd2, 8'h00, 1'b0);
    chk_wr("relock", 1'b1, 1'b0);
    step(2'd2, 1'b1, 2'b10, 2'd3, 8'h00, 1'b0);
    chk_wr("non_admin_lock", 1'b0, 1'b1);
    step(2'd3, 1'b1, 2'b11, 2'd3, 8'h00, 1'b0);
    chk_wr("reserved_op", 1'b0, 1'b1);
    step(2'd0, 1'b0, 2'b00, 2'd2, 8'h00, 1'b1);
    n_checks++;
    if (rd_data !== 8'h00) begin
      n_fail++;
      $display("FAIL locked_data: got %h required 00", rd_data);
    end
  endtask

  task automatic test_read_collision();
    step(2'd2, 1'b1, 2'b00, 2'd1, 8'h11, 1'b1);
    n_checks++;
    if (wr_ack !== 1'b1 || rd_data !== 8'hA5 || rd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL collision: ack=%b rd=%b/%h required 1 1/a5",
               wr_ack, rd_valid, rd_data);
    end
    step(2'd0, 1'b0, 2'b00, 2'd1, 8'h00, 1'b1);
    n_checks++;
    if (rd_data !== 8'h11) begin
      n_fail++;
      $display("FAIL after_collision: got %h required 11", rd_data);
    end
  endtask

  task automatic test_hold();
    step(2'd0, 1'b0, 2'b00, 2'd3, 8'h00, 1'b0);
    step(2'd0, 1'b0, 2'b00, 2'd0, 8'h00, 1'b0);
    n_checks++;
    if (rd_valid !== 1'b0 || rd_data !== 8'h11 || wr_ack || wr_err) begin
      n_fail++;
      $display("FAIL hold: got %b/%h ack/err=%b%b required 0/11 00",
               rd_valid, rd_data, wr_ack, wr_err);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] o;
    for (int i = 0; i < 400; i++) begin
      o = 2'($urandom_range(0, 3));
      if (o == 2'b10 && $urandom_range(0, 7) != 0) o = 2'b00;
      step(2'($urandom), 1'($urandom), o, 2'($urandom),
           8'($urandom), 1'($urandom));
      n_checks++;
      if (wr_ack !== exp_ack || wr_err !== exp_err ||
          rd_valid !== exp_rv || rd_data !== exp_rd) begin
        n_fail++;
        $display("FAIL random[%0d]: ack/err/rv=%b%b%b rd=%h required %b%b%b %h",
                 i, wr_ack, wr_err, rd_valid, rd_data,
                 exp_ack, exp_err, exp_rv, exp_rd);
      end
    end
`ifdef USER_LOCK_VIOL_CNT_EN
    n_checks++;
    if (int'(viol_cnt) != m_viol) begin
      n_fail++;
      $display("FAIL viol_random: got %0d required %0d", viol_cnt, m_viol);
    end
`endif
  endtask

  task automatic test_reset_mid();
    step(2'd3, 1'b1, 2'b10, 2'd3, 8'h00, 1'b0);
    usr_id = 2'd2; wr_en = 1'b1; op = 2'b00;
    addr = 2'd3; data_in = 8'hEE; rd_en = 1'b1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({rd_data, rd_valid, wr_ack, wr_err} !== 11'd0) begin
      n_fail++;
      $display("FAIL mid_reset_outs: got %h/%b%b%b required 0",
               rd_data, rd_valid, wr_ack, wr_err);
    end
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    model_reset();
    rst_n = 1'b1;
    step(2'd0, 1'b0, 2'b00, 2'd0, 8'h00, 1'b0);
    chk_wr("post_reset_quiet", 1'b0, 1'b0);
    step(2'd2, 1'b1, 2'b00, 2'd3, 8'h5A, 1'b0);
    chk_wr("post_reset_write", 1'b1, 1'b0);
    step(2'd2, 1'b1, 2'b00, 2'd2, 8'hC3, 1'b1);
    chk_wr("post_reset_unlocked", 1'b1, 1'b0);
    step(2'd0, 1'b0, 2'b00, 2'd3, 8'h00, 1'b1);
    n_checks++;
    if (rd_data !== 8'h5A) begin
      n_fail++;
      $display("FAIL post_reset_read: got %h required 5a", rd_data);
    end
`ifdef USER_LOCK_VIOL_CNT_EN
    n_checks++;
    if (viol_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL post_reset_viol: got %0d required 0", viol_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_write_ok();
    test_write_denied();
    test_set_owner();
    test_lock();
    test_read_collision();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
